mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_picker.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory request arbiter.
// Contents:
//   RW_*        2-bit request flag encodings used on every request port
//   ARB_*       arbitration mode selectors for the MODE parameter
//   arb_state_t arbiter FSM state encoding
//   is_active   true for a flag that names a real read or write
package mem_port_arbiter_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // 2'b11 is deliberately treated the same as idle.
  function automatic logic is_active(input logic [1:0] flag);
    return (flag == RW_READ) || (flag == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner selection for the memory request arbiter.
// Ports:
//   eligible   in  PORTS  ports allowed to win this cycle
//   last_grant in  IDX_W  most recently completed port (round-robin pointer)
//   valid      out 1      at least one port is eligible
//   idx        out IDX_W  winning port index
// MODE = ARB_RR scans upward from last_grant+1 with wrap; MODE = ARB_FIXED
// takes the lowest eligible index.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int MODE  = ARB_RR,
  localparam int IDX_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // The first hit in scan order wins; later hits are ignored via !valid.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (MODE == ARB_FIXED) begin
        cand = IDX_W'(k);
      end else begin
        cand = IDX_W'((int'(last_grant) + 1 + k) % PORTS);
      end
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-to-1 memory request arbiter in front of the memory controller.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_rw_flag       per-port request flag (00 idle, 01 read, 10 write)
//   req_addr/w_data/w_mask  per-port request payload, held until req_done
//   req_r_data        shared read data, meaningful with a read's req_done
//   req_busy          one-hot: port currently granted and in flight
//   req_done          one-cycle completion pulse for the granted port
//   mem_*_o           registered request towards the controller
//   mem_r_data_i, mem_busy_i, mem_done_i  controller response/handshake
// One transaction is in flight at a time. Every output is registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PORTS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE   = ARB_RR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2*PORTS-1:0]         req_rw_flag,
  input  logic [ADDR_W*PORTS-1:0]    req_addr,
  input  logic [DATA_W*PORTS-1:0]    req_w_data,
  input  logic [(DATA_W/8)*PORTS-1:0] req_w_mask,
  output logic [DATA_W-1:0]          req_r_data,
  output logic [PORTS-1:0]           req_busy,
  output logic [PORTS-1:0]           req_done,
  output logic [1:0]                 mem_rw_flag_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_w_data_o,
  output logic [DATA_W/8-1:0]        mem_w_mask_o,
  input  logic [DATA_W-1:0]          mem_r_data_i,
  input  logic                       mem_busy_i,
  input  logic                       mem_done_i
);

  localparam int IDX_W  = $clog2(PORTS);
  localparam int MASK_W = DATA_W / 8;

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;

  logic [1:0]        port_flag [PORTS];
  logic [ADDR_W-1:0] port_addr [PORTS];
  logic [DATA_W-1:0] port_data [PORTS];
  logic [MASK_W-1:0] port_mask [PORTS];
  logic [PORTS-1:0]  eligible;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  // A port whose done pulse is on the outputs right now is not eligible,
  // so a requester still holding its flag in that cycle is not re-granted.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      port_flag[p] = req_rw_flag[2*p +: 2];
      port_addr[p] = req_addr[ADDR_W*p +: ADDR_W];
      port_data[p] = req_w_data[DATA_W*p +: DATA_W];
      port_mask[p] = req_w_mask[MASK_W*p +: MASK_W];
      eligible[p]  = is_active(port_flag[p]) && !req_done[p];
    end
  end

  mem_port_arbiter_rr_picker #(
    .PORTS (PORTS),
    .MODE  (MODE)
  ) u_rr_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // IDLE -> BUSY: latch winner payload. BUSY -> IDLE: on controller done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant         <= '0;
      last_grant    <= IDX_W'(PORTS - 1);
      mem_rw_flag_o <= RW_IDLE;
      mem_addr_o    <= '0;
      mem_w_data_o  <= '0;
      mem_w_mask_o  <= '0;
      req_busy      <= '0;
      req_done      <= '0;
      req_r_data    <= '0;
    end else begin
      req_done <= '0;
      case (state)
        ST_IDLE: begin
          // Controller back-pressure only gates new grants.
          if (pick_valid && !mem_busy_i) begin
            state         <= ST_BUSY;
            grant         <= pick_idx;
            mem_rw_flag_o <= port_flag[pick_idx];
            mem_addr_o    <= port_addr[pick_idx];
            mem_w_data_o  <= port_data[pick_idx];
            mem_w_mask_o  <= port_mask[pick_idx];
            req_busy      <= {{(PORTS-1){1'b0}}, 1'b1} << pick_idx;
          end
        end
        ST_BUSY: begin
          if (mem_done_i) begin
            state           <= ST_IDLE;
            req_done[grant] <= 1'b1;
            if (mem_rw_flag_o == RW_READ) begin
              req_r_data <= mem_r_data_i;
            end
            last_grant    <= grant;
            mem_rw_flag_o <= RW_IDLE;
            req_busy      <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1), each with a simple controller
// responder, a transaction-level reference model and per-cycle comparison.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int P  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2*P-1:0]  rw    [2];
  logic [AW*P-1:0] ra    [2];
  logic [DW*P-1:0] rwd   [2];
  logic [MW*P-1:0] rm    [2];
  logic [DW-1:0]   rdata [2];
  logic [P-1:0]    busy  [2];
  logic [P-1:0]    done  [2];
  logic [1:0]      mflag [2];
  logic [AW-1:0]   maddr [2];
  logic [DW-1:0]   mwdata[2];
  logic [MW-1:0]   mmask [2];
  logic [DW-1:0]   mrdata[2];
  logic            mbusy [2];
  logic            mdone [2];
  logic            rsp_done  [2];
  logic            stray_done[2];

  always_comb begin
    for (int i = 0; i < 2; i++) mdone[i] = rsp_done[i] | stray_done[i];
  end

  mem_port_arbiter #(.PORTS(P), .ADDR_W(AW), .DATA_W(DW), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_rw_flag(rw[0]), .req_addr(ra[0]), .req_w_data(rwd[0]), .req_w_mask(rm[0]),
    .req_r_data(rdata[0]), .req_busy(busy[0]), .req_done(done[0]),
    .mem_rw_flag_o(mflag[0]), .mem_addr_o(maddr[0]), .mem_w_data_o(mwdata[0]),
    .mem_w_mask_o(mmask[0]), .mem_r_data_i(mrdata[0]), .mem_busy_i(mbusy[0]),
    .mem_done_i(mdone[0])
  );

  mem_port_arbiter #(.PORTS(P), .ADDR_W(AW), .DATA_W(DW), .MODE(ARB_FIXED)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_rw_flag(rw[1]), .req_addr(ra[1]), .req_w_data(rwd[1]), .req_w_mask(rm[1]),
    .req_r_data(rdata[1]), .req_busy(busy[1]), .req_done(done[1]),
    .mem_rw_flag_o(mflag[1]), .mem_addr_o(maddr[1]), .mem_w_data_o(mwdata[1]),
    .mem_w_mask_o(mmask[1]), .mem_r_data_i(mrdata[1]), .mem_busy_i(mbusy[1]),
    .mem_done_i(mdone[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Controller responder: done arrives rsp_lat cycles after the request appears.
  int            rsp_lat[2] = '{1, 1};
  logic [DW-1:0] rsp_val[2] = '{32'h0, 32'h0};
  int            rsp_cnt[2] = '{0, 0};

  initial begin
    for (int i = 0; i < 2; i++) begin
      rsp_done[i] = 1'b0; stray_done[i] = 1'b0; mrdata[i] = '0; mbusy[i] = 1'b0;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rsp_cnt[i] = 0; rsp_done[i] = 1'b0; mrdata[i] = '0;
      end else if (rsp_done[i]) begin
        rsp_done[i] = 1'b0; rsp_cnt[i] = 0;
      end else if (mflag[i] != RW_IDLE) begin
        if (rsp_cnt[i] >= rsp_lat[i]) begin
          rsp_done[i] = 1'b1; mrdata[i] = rsp_val[i];
        end else begin
          rsp_cnt[i]++;
        end
      end
    end
  end

  // Reference model: expected outputs derived from the arbitration rules.
  int            mode_of[2] = '{0, 1};
  logic [1:0]    e_flag [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_wdata[2];
  logic [MW-1:0] e_mask [2];
  logic [DW-1:0] e_rdata[2];
  logic [P-1:0]  e_busy [2];
  logic [P-1:0]  e_done [2];
  bit            m_infl [2];
  int            m_port [2];
  int            m_last [2];
  int            m_log  [2][$];
  logic [P-1:0]  m_elig;
  int            m_win;

  // Round-robin priority = distance past the last completed port.
  function automatic int choose(input int inst, input logic [P-1:0] elig);
    int best  = -1;
    int bestd = P;
    int d;
    for (int p = 0; p < P; p++) begin
      if (elig[p]) begin
        d = (mode_of[inst] == 0) ? (p - m_last[inst] - 1 + 2*P) % P : p;
        if (d < bestd) begin bestd = d; best = p; end
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        e_flag[i] = 0; e_addr[i] = 0; e_wdata[i] = 0; e_mask[i] = 0;
        e_rdata[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        m_infl[i] = 0; m_port[i] = 0; m_last[i] = P - 1;
      end else if (!m_infl[i]) begin
        for (int p = 0; p < P; p++)
          m_elig[p] = (rw[i][2*p +: 2] == RW_READ || rw[i][2*p +: 2] == RW_WRITE) && !e_done[i][p];
        e_done[i] = 0;
        if (m_elig != 0 && !mbusy[i]) begin
          m_win      = choose(i, m_elig);
          e_flag[i]  = rw[i][2*m_win +: 2];
          e_addr[i]  = ra[i][AW*m_win +: AW];
          e_wdata[i] = rwd[i][DW*m_win +: DW];
          e_mask[i]  = rm[i][MW*m_win +: MW];
          e_busy[i]  = 0;
          e_busy[i][m_win] = 1'b1;
          m_infl[i]  = 1;
          m_port[i]  = m_win;
          m_log[i].push_back(m_win);
        end
      end else begin
        e_done[i] = 0;
        if (mdone[i]) begin
          e_done[i][m_port[i]] = 1'b1;
          if (e_flag[i] == RW_READ) e_rdata[i] = mrdata[i];
          m_last[i] = m_port[i];
          e_flag[i] = RW_IDLE;
          e_busy[i] = 0;
          m_infl[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison, grant logging and done counting.
  bit           cmp_en = 0;
  int           dut_log[2][$];
  logic [P-1:0] prev_busy[2] = '{4'b0, 4'b0};
  int           done_cnt[2][P];

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("i%0d_flag", i), 32'(mflag[i]), 32'(e_flag[i]));
        check($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(e_busy[i]));
        check($sformatf("i%0d_done", i), 32'(done[i]), 32'(e_done[i]));
        check($sformatf("i%0d_rdata", i), rdata[i], e_rdata[i]);
        if (e_flag[i] != RW_IDLE) check($sformatf("i%0d_addr", i), maddr[i], e_addr[i]);
        if (e_flag[i] == RW_WRITE) begin
          check($sformatf("i%0d_wdata", i), mwdata[i], e_wdata[i]);
          check($sformatf("i%0d_mask", i), 32'(mmask[i]), 32'(e_mask[i]));
        end
        if (busy[i] != 0 && prev_busy[i] == 0)
          for (int p = 0; p < P; p++) if (busy[i][p]) dut_log[i].push_back(p);
        prev_busy[i] = busy[i];
        for (int p = 0; p < P; p++) if (done[i][p]) done_cnt[i][p]++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 2; i++) begin
      rw[i] = '0; ra[i] = '0; rwd[i] = '0; rm[i] = '0;
      mbusy[i] = 1'b0; stray_done[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input int p, input logic [1:0] f,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    rw[i][2*p +: 2]   = f;
    ra[i][AW*p +: AW] = a;
    rwd[i][DW*p +: DW] = d;
    rm[i][MW*p +: MW] = m;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      dut_log[i].delete(); m_log[i].delete();
      for (int p = 0; p < P; p++) done_cnt[i][p] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_flag", i), 32'(mflag[i]), 32'h0);
      check($sformatf("rst%0d_addr", i), maddr[i], 32'h0);
      check($sformatf("rst%0d_wdata", i), mwdata[i], 32'h0);
      check($sformatf("rst%0d_mask", i), 32'(mmask[i]), 32'h0);
      check($sformatf("rst%0d_busy", i), 32'(busy[i]), 32'h0);
      check($sformatf("rst%0d_done", i), 32'(done[i]), 32'h0);
      check($sformatf("rst%0d_rdata", i), rdata[i], 32'h0);
    end
    clr_all();
    cmp_en = 1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int i, input int n, input string name);
    int g = 0;
    while (dut_log[i].size() < n && g < 200) begin tick(); g++; end
    check(name, dut_log[i].size(), n);
  endtask

  task automatic wait_done(input int i, input int p, input string name);
    int g = 0;
    while (!done[i][p] && g < 50) begin tick(); g++; end
    check(name, 32'(done[i][p]), 32'h1);
  endtask

  // Release each port's flag in its done cycle until the instance is idle.
  task automatic drain(input int i, input string name);
    int g = 0;
    while ((rw[i] != 0 || busy[i] != 0) && g < 300) begin
      tick(); g++;
      for (int p = 0; p < P; p++) if (done[i][p]) rw[i][2*p +: 2] = RW_IDLE;
    end
    check(name, 32'(busy[i]), 32'h0);
  endtask

  task automatic check_log(input int i, input string name, input int exp[$]);
    check({name, "_len"}, dut_log[i].size(), exp.size());
    check({name, "_mlen"}, m_log[i].size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < dut_log[i].size()) check($sformatf("%s_dut%0d", name, k), dut_log[i][k], exp[k]);
      if (k < m_log[i].size())   check($sformatf("%s_mdl%0d", name, k), m_log[i][k], exp[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    clr_all();
    tick();
    do_reset();
    tick();

    // Single read: port 2, controller answers 3 cycles after issue.
    rsp_lat[0] = 3; rsp_val[0] = 32'hDEADBEEF;
    set_req(0, 2, RW_READ, 32'h100, 32'h0, 4'h0);
    tick();
    check("t1_addr", maddr[0], 32'h100);
    check("t1_flag", 32'(mflag[0]), 32'h1);
    check("t1_busy", 32'(busy[0]), 32'h4);
    n = 1;
    while (!done[0][2] && n < 20) begin tick(); n++; end
    check("t1_done_latency", n, 5);
    check("t1_done_vec", 32'(done[0]), 32'h4);
    check("t1_rdata", rdata[0], 32'hDEADBEEF);
    set_req(0, 2, RW_IDLE, 32'h0, 32'h0, 4'h0);
    tick();
    check("t1_done_pulse", 32'(done[0]), 32'h0);
    check("t1_flag_clear", 32'(mflag[0]), 32'h0);
    check("t1_rdata_hold", rdata[0], 32'hDEADBEEF);

    // Controller done while idle is ignored.
    stray_done[0] = 1'b1;
    tick();
    stray_done[0] = 1'b0;
    tick();
    check("t1b_stray_done", 32'(done[0]), 32'h0);
    check("t1b_stray_busy", 32'(busy[0]), 32'h0);

    // Round-robin fairness from reset with all four ports requesting.
    do_reset();
    clear_logs();
    rsp_lat[0] = 1; rsp_val[0] = 32'h0BADF00D;
    for (int p = 0; p < P; p++) set_req(0, p, RW_READ, 32'h1000 + 4*p, 32'h0, 4'h0);
    wait_log(0, 5, "t2_grants");
    rw[0] = '0;
    for (int p = 0; p < P; p++) check($sformatf("t2_done_cnt%0d", p), done_cnt[0][p], 1);
    for (int k = 0; k < 8; k++) tick();
    check_log(0, "t2_order", '{0, 1, 2, 3, 0});

    // Fixed priority with ports 1, 2 and 3 continuously requesting.
    clear_logs();
    rsp_lat[1] = 2; rsp_val[1] = 32'hCAFE0001;
    for (int p = 1; p < P; p++) set_req(1, p, RW_READ, 32'h2000 + 4*p, 32'h0, 4'h0);
    wait_log(1, 4, "t3_grants");
    drain(1, "t3_drain");
    check_log(1, "t3_order", '{1, 2, 1, 2, 1, 3});

    // Masked write held off by controller back-pressure.
    rsp_lat[0] = 2;
    mbusy[0] = 1'b1;
    set_req(0, 0, RW_WRITE, 32'h40, 32'h12345678, 4'b0011);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t4_hold_flag%0d", k), 32'(mflag[0]), 32'h0);
      check($sformatf("t4_hold_busy%0d", k), 32'(busy[0]), 32'h0);
    end
    mbusy[0] = 1'b0;
    tick();
    check("t4_flag", 32'(mflag[0]), 32'h2);
    check("t4_addr", maddr[0], 32'h40);
    check("t4_wdata", mwdata[0], 32'h12345678);
    check("t4_mask", 32'(mmask[0]), 32'h3);
    wait_done(0, 0, "t4_done");
    set_req(0, 0, RW_IDLE, 32'h0, 32'h0, 4'h0);
    tick();
    check("t4_rdata_kept", rdata[0], 32'h0BADF00D);

    // Done-cycle exclusion: port 1 holds its flag through req_done.
    rsp_lat[0] = 1;
    set_req(0, 1, RW_READ, 32'h80, 32'h0, 4'h0);
    wait_done(0, 1, "t5_done");
    tick();
    check("t5_no_regrant", 32'(busy[0]), 32'h0);
    tick();
    check("t5_regrant", 32'(busy[0]), 32'h2);
    drain(0, "t5_drain");

    // Reset in the middle of a transaction, then port 0 beats port 3.
    rsp_lat[0] = 5;
    set_req(0, 2, RW_READ, 32'h200, 32'h0, 4'h0);
    tick();
    tick();
    check("t6_inflight", 32'(busy[0]), 32'h4);
    do_reset();
    clear_logs();
    check("t6_no_done", 32'(done[0]), 32'h0);
    rsp_lat[0] = 1;
    set_req(0, 3, RW_READ, 32'h300, 32'h0, 4'h0);
    set_req(0, 0, RW_READ, 32'h000, 32'h0, 4'h0);
    tick();
    check("t6_first", 32'(busy[0]), 32'h1);
    drain(0, "t6_drain");
    check_log(0, "t6_order", '{0, 3});
    check("t6_port2_dones", done_cnt[0][2], 0);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
